routing_target_prog: RTL and testbench
======================================

Name: routing_target_prog

Overview:
- Programmable successor to the fixed per-NI target routing LUT.
- Maps a packet's source ID (SOURCEWD bits) to a return-path route word (first hop in LSBs, last hop in MSBs) using a small fully-associative table.
- Software or the NoC config master loads the table at runtime; lookups use a valid/ready handshake with one registered response stage.
- Sits between the target NI's request-header decoder and the response packetiser.

Parameters:
- SOURCEWD, 4, source-ID key width.
- PATHWD, 7, route word width.
- NUM_ENTRIES, 8, table depth (2..32).
- IDXWD, 3, entry index width (ceil(log2(NUM_ENTRIES))).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  IDXWD  entry to write.
- cfg_key  in  SOURCEWD  source ID stored in the entry.
- cfg_path  in  PATHWD  route stored in the entry.
- cfg_valid_bit  in  1  entry valid flag to store (0 invalidates the entry).
- cfg_clear  in  1  invalidate all entries in one cycle.
- req_valid  in  1  lookup request valid.
- req_ready  out  1  lookup accepted when high with req_valid.
- req_source  in  SOURCEWD  source ID to look up.
- resp_valid  out  1  lookup result valid.
- resp_ready  in  1  consumer accepts result.
- resp_path  out  PATHWD  route word (0 on miss).
- resp_miss  out  1  no valid entry matched.
- miss_count  out  16  saturating count of misses since reset or cfg_clear.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All entry valid bits = 0; keys and paths = 0.
  - resp_valid = 0, resp_path = 0, resp_miss = 0, miss_count = 0.
  - req_ready deasserts with reset_n low.
- Lookup:
  - Combinational compare of req_source against all valid entries.
  - Hit: path of the lowest-indexed matching valid entry (duplicate keys resolve to the lowest index).
  - Miss: path = 0, miss = 1.
- Response register:
  - Captures the lookup result on a req_valid & req_ready handshake.
  - Latency: result visible on resp_* the cycle after the handshake.
- req_ready = !resp_valid | resp_ready. This gives full throughput of one lookup per cycle when the consumer does not stall.
- Stall: while resp_valid & !resp_ready, resp_path and resp_miss hold stable and req_ready = 0.
- resp_valid:
  - Sets on a handshake.
  - Clears when resp_ready is high and no new handshake occurs in the same cycle.
  - Stays 1 on back-to-back handshakes.
- Config writes:
  - On cfg_we, entry cfg_idx gets {cfg_valid_bit, cfg_key, cfg_path} at the clock edge.
  - cfg_idx >= NUM_ENTRIES: write ignored.
- Write/lookup collision, same cycle: the lookup uses the pre-write table contents. The new entry is visible to handshakes from the next cycle.
- cfg_clear:
  - Invalidates all entries and zeroes miss_count.
  - Takes priority over cfg_we in the same cycle.
  - Does not disturb an already-registered response.
- miss_count:
  - Increments on each handshake whose result is a miss.
  - Saturates at 16'hFFFF.
  - If cfg_clear and a miss handshake occur in the same cycle, the result is 0.
- Reset mid-transfer: pending response discarded; resp_valid = 0 immediately.
- Route word semantics are opaque to this block; no hop-field checking.

Test Plan:
- Program entries {0:key 4'h0 path 7'b0000000}, {1:4'h6, 7'b0000010}, {2:4'hd, 7'b0000011}, {3:4'h9, 7'b0011100}. Look up 6, d, 9, 0 back-to-back with resp_ready = 1 -> responses one cycle later: 0000010, 0000011, 0011100, 0000000, all miss = 0; req_ready stays 1.
- Lookup 4'h3 on the table above -> resp_path = 0, resp_miss = 1, miss_count = 1. Drive 65540 further misses -> miss_count saturates at 16'hFFFF.
- Hold resp_ready = 0 after a handshake for 5 cycles -> resp_valid = 1, resp_path stable, req_ready = 0. Release -> the next request is accepted the same cycle.
- In one cycle, write entry 4 = {4'h3, 7'b1010101} while looking up 4'h3 -> miss. Next-cycle lookup of 4'h3 -> hit, 1010101.
- Duplicate key: entry 5 = {4'h6, 7'b1111111} with entry 1 = {4'h6, 7'b0000010} -> lookup 6 returns 0000010. Invalidate entry 1 -> lookup 6 returns 1111111.
- Assert cfg_clear together with cfg_we to entry 0, then look up 0 -> miss, miss_count = 1. Pulse reset_n low while resp_valid = 1 -> resp_valid drops asynchronously and the table is empty after reset.

Source files
------------

// File: rtl/routing_target_prog.sv
// routing_target_prog: programmable source-ID to return-route lookup table with registered response
module routing_target_prog #(
  parameter int SOURCEWD    = 4,
  parameter int PATHWD      = 7,
  parameter int NUM_ENTRIES = 8,
  parameter int IDXWD       = 3
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_cfg_we,
  input  logic [IDXWD-1:0]    i_cfg_idx,
  input  logic [SOURCEWD-1:0] i_cfg_key,
  input  logic [PATHWD-1:0]   i_cfg_path,
  input  logic                i_cfg_valid_bit,
  input  logic                i_cfg_clear,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [SOURCEWD-1:0] i_req_source,
  output logic                o_resp_valid,
  input  logic                i_resp_ready,
  output logic [PATHWD-1:0]   o_resp_path,
  output logic                o_resp_miss,
  output logic [15:0]         o_miss_count
);
  logic                r_valid [NUM_ENTRIES];
  logic [SOURCEWD-1:0] r_key   [NUM_ENTRIES];
  logic [PATHWD-1:0]   r_path  [NUM_ENTRIES];
  logic                r_resp_valid;
  logic [PATHWD-1:0]   r_resp_path;
  logic                r_resp_miss;
  logic [15:0]         r_miss_count;
  logic                w_hit;
  logic [PATHWD-1:0]   w_path;
  logic                w_hs;

  assign o_req_ready  = i_reset_n & (~r_resp_valid | i_resp_ready);
  assign w_hs         = i_req_valid & o_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_path  = r_resp_path;
  assign o_resp_miss  = r_resp_miss;
  assign o_miss_count = r_miss_count;

  // Associative match; scanning downward lets the lowest matching index win
  always_comb begin
    w_hit  = 1'b0;
    w_path = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--)
      if (r_valid[i] && r_key[i] == i_req_source) begin
        w_hit  = 1'b1;
        w_path = r_path[i];
      end
  end

  // Table storage: clear beats write, out-of-range indices fall through untouched
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_key[i]   <= '0;
        r_path[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (i_cfg_clear) r_valid[i] <= 1'b0;
        else if (i_cfg_we && int'(i_cfg_idx) == i) begin
          r_valid[i] <= i_cfg_valid_bit;
          r_key[i]   <= i_cfg_key;
          r_path[i]  <= i_cfg_path;
        end
      end
    end
  end

  // Response stage: load on handshake, drop valid once consumed with nothing new behind it
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_resp_valid <= 1'b0;
      r_resp_path  <= '0;
      r_resp_miss  <= 1'b0;
    end else if (w_hs) begin
      r_resp_valid <= 1'b1;
      r_resp_path  <= w_path;
      r_resp_miss  <= ~w_hit;
    end else if (i_resp_ready) r_resp_valid <= 1'b0;
  end

  // Saturating miss counter, zeroed by table clear even when a miss lands the same cycle
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_miss_count <= '0;
    else if (i_cfg_clear) r_miss_count <= '0;
    else if (w_hs && !w_hit && r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
  end
endmodule

// File: tb/tb_routing_target_prog.sv
// tb_routing_target_prog: directed checks of lookup, handshake, config and miss counting
module tb_routing_target_prog;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0, cfg_valid_bit = 1'b0, cfg_clear = 1'b0;
  logic [2:0] cfg_idx = '0;
  logic [3:0] cfg_key = '0, req_source = '0;
  logic [6:0] cfg_path = '0, resp_path;
  logic       req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b1, resp_miss;
  logic [15:0] miss_count;
  int checks = 0, errors = 0;

  routing_target_prog dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx),
    .i_cfg_key(cfg_key), .i_cfg_path(cfg_path), .i_cfg_valid_bit(cfg_valid_bit),
    .i_cfg_clear(cfg_clear), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_source(req_source), .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_path(resp_path), .o_resp_miss(resp_miss), .o_miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [3:0] key, input logic [6:0] path, input logic v);
    cfg_we = 1'b1; cfg_idx = idx; cfg_key = key; cfg_path = path; cfg_valid_bit = v;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic lookup(input logic [3:0] src);
    req_valid = 1'b1; req_source = src;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_resp_valid", 16'(resp_valid), 16'd0);
    chk("rst_resp_path", 16'(resp_path), 16'd0);
    chk("rst_resp_miss", 16'(resp_miss), 16'd0);
    chk("rst_miss_count", miss_count, 16'd0);
    chk("rst_req_ready", 16'(req_ready), 16'd0);
    #20 rst_n = 1'b1;
    tick();
    cfg(3'd0, 4'h0, 7'b0000000, 1'b1);
    cfg(3'd1, 4'h6, 7'b0000010, 1'b1);
    cfg(3'd2, 4'hd, 7'b0000011, 1'b1);
    cfg(3'd3, 4'h9, 7'b0011100, 1'b1);
    // back-to-back hits
    req_valid = 1'b1; req_source = 4'h6;
    chk("b2b_ready0", 16'(req_ready), 16'd1);
    tick();
    chk("b2b_path6", 16'(resp_path), 16'b0000010);
    chk("b2b_valid6", 16'(resp_valid), 16'd1);
    req_source = 4'hd;
    chk("b2b_ready1", 16'(req_ready), 16'd1);
    tick();
    chk("b2b_pathd", 16'(resp_path), 16'b0000011);
    req_source = 4'h9;
    chk("b2b_ready2", 16'(req_ready), 16'd1);
    tick();
    chk("b2b_path9", 16'(resp_path), 16'b0011100);
    chk("b2b_miss9", 16'(resp_miss), 16'd0);
    req_source = 4'h0;
    chk("b2b_ready3", 16'(req_ready), 16'd1);
    tick();
    chk("b2b_path0", 16'(resp_path), 16'b0000000);
    chk("b2b_miss0", 16'(resp_miss), 16'd0);
    chk("b2b_valid0", 16'(resp_valid), 16'd1);
    req_valid = 1'b0;
    tick();
    chk("drain_valid", 16'(resp_valid), 16'd0);
    chk("hits_no_miss", miss_count, 16'd0);
    // miss and saturation
    lookup(4'h3);
    chk("miss_path", 16'(resp_path), 16'd0);
    chk("miss_flag", 16'(resp_miss), 16'd1);
    chk("miss_count1", miss_count, 16'd1);
    req_valid = 1'b1; req_source = 4'h3;
    repeat (65533) tick();
    chk("miss_count_fffe", miss_count, 16'hFFFE);
    tick();
    chk("miss_count_ffff", miss_count, 16'hFFFF);
    repeat (6) tick();
    req_valid = 1'b0;
    tick();
    chk("miss_count_sat", miss_count, 16'hFFFF);
    chk("sat_valid_drop", 16'(resp_valid), 16'd0);
    // stall
    resp_ready = 1'b0; req_valid = 1'b1; req_source = 4'h6;
    tick();
    req_source = 4'hd;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 16'(resp_valid), 16'd1);
      chk("stall_path", 16'(resp_path), 16'b0000010);
      chk("stall_ready", 16'(req_ready), 16'd0);
      tick();
    end
    resp_ready = 1'b1;
    #1 chk("release_ready", 16'(req_ready), 16'd1);
    tick();
    chk("release_path", 16'(resp_path), 16'b0000011);
    chk("release_valid", 16'(resp_valid), 16'd1);
    req_valid = 1'b0;
    tick();
    // write/lookup collision
    cfg_we = 1'b1; cfg_idx = 3'd4; cfg_key = 4'h3; cfg_path = 7'b1010101; cfg_valid_bit = 1'b1;
    req_valid = 1'b1; req_source = 4'h3;
    tick();
    cfg_we = 1'b0;
    chk("coll_miss", 16'(resp_miss), 16'd1);
    chk("coll_path", 16'(resp_path), 16'd0);
    tick();
    req_valid = 1'b0;
    chk("coll_next_miss", 16'(resp_miss), 16'd0);
    chk("coll_next_path", 16'(resp_path), 16'b1010101);
    // duplicate keys
    cfg(3'd5, 4'h6, 7'b1111111, 1'b1);
    lookup(4'h6);
    chk("dup_low_idx", 16'(resp_path), 16'b0000010);
    cfg(3'd1, 4'h6, 7'b0000010, 1'b0);
    lookup(4'h6);
    chk("dup_after_inval", 16'(resp_path), 16'b1111111);
    // clear with a held response and a competing write
    resp_ready = 1'b0;
    lookup(4'h6);
    cfg_clear = 1'b1;
    cfg(3'd0, 4'h0, 7'b1010101, 1'b1);
    cfg_clear = 1'b0;
    chk("clear_count", miss_count, 16'd0);
    chk("clear_keep_valid", 16'(resp_valid), 16'd1);
    chk("clear_keep_path", 16'(resp_path), 16'b1111111);
    resp_ready = 1'b1;
    lookup(4'h0);
    chk("clear_miss", 16'(resp_miss), 16'd1);
    chk("clear_miss_path", 16'(resp_path), 16'd0);
    chk("clear_count1", miss_count, 16'd1);
    // async reset mid-transfer
    cfg(3'd2, 4'hd, 7'b0000011, 1'b1);
    resp_ready = 1'b0;
    lookup(4'hd);
    chk("pre_rst_valid", 16'(resp_valid), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 16'(resp_valid), 16'd0);
    chk("arst_ready", 16'(req_ready), 16'd0);
    chk("arst_count", miss_count, 16'd0);
    #3 rst_n = 1'b1;
    resp_ready = 1'b1;
    tick();
    lookup(4'hd);
    chk("post_rst_miss", 16'(resp_miss), 16'd1);
    chk("post_rst_path", 16'(resp_path), 16'd0);
    chk("post_rst_count", miss_count, 16'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
